// File: rtl/alu_slice_sequencer_if.sv
// Request/response bundle between a requester and alu_slice_sequencer.
// master = requester side, slave = sequencer side.
interface alu_slice_sequencer_if #(
  parameter int OPW = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic [1:0]     op_fn;
  logic           op_cin;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_result;
  logic           out_cout;
  logic           out_n;
  logic           out_z;
  logic           out_v;

  modport master (
    output in_valid, op_a, op_b, op_fn, op_cin, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_cout, out_n, out_z, out_v
  );

  modport slave (
    input  in_valid, op_a, op_b, op_fn, op_cin, out_ready,
    output in_ready, out_valid, out_result,
    output out_cout, out_n, out_z, out_v
  );
endinterface

// File: rtl/alu_slice_sequencer.sv
// Runs wide operands through a WIDTH-bit ALU one slice per cycle, LSB first.
// Optional ALU_SEQ_PERF_CNT_EN adds the perf_ops completed-op counter.
module alu_slice_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SLICES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_slice_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [1:0]           alu_fn,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout,
  input  logic                 alu_v
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]          perf_ops
`endif
);
  localparam int OPW = WIDTH * SLICES;
  localparam int IW  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);
  localparam logic [1:0] FN_ADD = 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [1:0]     fn_q, fn_d;
  logic           carry_q, carry_d;
  logic [OPW-1:0] res_q, res_d;
  logic           zacc_q, zacc_d;
  logic           valid_q, valid_d;
  logic [OPW-1:0] result_q, result_d;
  logic           cout_q, cout_d;
  logic           n_q, n_d;
  logic           z_q, z_d;
  logic           v_q, v_d;
  logic           is_add;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0]    perf_q, perf_d;
`endif

  assign is_add = (fn_q == FN_ADD);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    fn_d     = fn_q;
    carry_d  = carry_q;
    res_d    = res_q;
    zacc_d   = zacc_q;
    valid_d  = valid_q;
    result_d = result_q;
    cout_d   = cout_q;
    n_d      = n_q;
    z_d      = z_q;
    v_d      = v_q;
`ifdef ALU_SEQ_PERF_CNT_EN
    perf_d   = perf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          fn_d    = bus.op_fn;
          carry_d = (bus.op_fn == FN_ADD) & bus.op_cin;
          idx_d   = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*WIDTH +: WIDTH] = alu_result;
        carry_d = is_add & alu_cout;
        zacc_d  = zacc_q & (alu_result == '0);
        if (idx_q == LAST) begin
          result_d = res_d;
          n_d      = res_d[OPW-1];
          z_d      = zacc_d;
          cout_d   = carry_d;
          v_d      = is_add & alu_v;
          valid_d  = 1'b1;
          idx_d    = '0;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
`ifdef ALU_SEQ_PERF_CNT_EN
          if (perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fn_q     <= '0;
      carry_q  <= 1'b0;
      res_q    <= '0;
      zacc_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
      perf_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      carry_q  <= carry_d;
      res_q    <= res_d;
      zacc_q   <= zacc_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      n_q      <= n_d;
      z_q      <= z_d;
      v_q      <= v_d;
`ifdef ALU_SEQ_PERF_CNT_EN
      perf_q   <= perf_d;
`endif
    end
  end

  // ALU inputs are forced to zero whenever no slice is in flight
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fn  = '0;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a   = a_q[idx_q*WIDTH +: WIDTH];
      alu_b   = b_q[idx_q*WIDTH +: WIDTH];
      alu_fn  = fn_q;
      alu_cin = carry_q;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_n      = n_q;
  assign bus.out_z      = z_q;
  assign bus.out_v      = v_q;
`ifdef ALU_SEQ_PERF_CNT_EN
  assign perf_ops       = perf_q;
`endif
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer with a 4-bit ALU model attached.
// Perf counter scenario runs only when ALU_SEQ_PERF_CNT_EN is defined.
module tb_alu_slice_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_fn;
  logic       alu_cin, alu_cout, alu_v;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] perf_ops;
`endif
  int checks = 0;
  int errors = 0;

  alu_slice_sequencer_if #(.OPW(16)) bus ();

  alu_slice_sequencer #(.WIDTH(4), .SLICES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fn     (alu_fn),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_v      (alu_v)
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    .perf_ops   (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  // Reference 4-bit ALU
  always_comb begin
    logic [4:0] s;
    s          = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    alu_result = 4'd0;
    alu_cout   = 1'b0;
    alu_v      = 1'b0;
    case (alu_fn)
      2'd0: begin
        alu_result = s[3:0];
        alu_cout   = s[4];
        alu_v      = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
      end
      2'd1: alu_result = alu_a & alu_b;
      2'd2: alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  // Issues one op starting #1 after a posedge; returns accept-to-valid
  // edge count (0 on timeout) and alu_cin seen on each slice.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] fn, input logic cin,
                        output int lat, output logic [3:0] cins);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_fn    = fn;
    bus.op_cin   = cin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat  = 0;
    cins = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) cins[k-1] = alu_cin;
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    checks++;
    if ({bus.out_result, bus.out_cout, bus.out_n, bus.out_z, bus.out_v}
        !== 20'd0) begin
      errors++;
      $display("FAIL reset_out: result=%h c=%b n=%b z=%b v=%b want 0",
               bus.out_result, bus.out_cout, bus.out_n, bus.out_z, bus.out_v);
    end
    checks++;
    if ({alu_a, alu_b, alu_fn, alu_cin} !== 11'd0) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h fn=%0d cin=%b want 0",
               alu_a, alu_b, alu_fn, alu_cin);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    int lat;
    logic [3:0] cins;
    run_op(16'h7FFF, 16'h0001, 2'd0, 1'b0, lat, cins);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL add_ovf_latency: got %0d want 4", lat);
    end
    checks++;
    if (bus.out_result !== 16'h8000 || bus.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf_result: got %h c=%b want 8000 c=0",
               bus.out_result, bus.out_cout);
    end
    checks++;
    if ({bus.out_n, bus.out_z, bus.out_v} !== 3'b101) begin
      errors++;
      $display("FAIL add_ovf_flags: nzv=%b%b%b want 101",
               bus.out_n, bus.out_z, bus.out_v);
    end
    checks++;
    if (cins !== 4'b1110) begin
      errors++;
      $display("FAIL add_ovf_carry_chain: cins=%b want 1110", cins);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
        || bus.out_result !== 16'h8000) begin
      errors++;
      $display("FAIL add_ovf_handshake: valid=%b ready=%b result=%h want 0 1 8000",
               bus.out_valid, bus.in_ready, bus.out_result);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    logic [3:0] cins;
    run_op(16'hFFFF, 16'h0000, 2'd0, 1'b1, lat, cins);
    checks++;
    if (lat != 4 || bus.out_result !== 16'h0000 || bus.out_cout !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap_result: lat=%0d result=%h c=%b want 4 0000 1",
               lat, bus.out_result, bus.out_cout);
    end
    checks++;
    if ({bus.out_n, bus.out_z, bus.out_v} !== 3'b010) begin
      errors++;
      $display("FAIL add_wrap_flags: nzv=%b%b%b want 010",
               bus.out_n, bus.out_z, bus.out_v);
    end
    checks++;
    if (cins !== 4'b1111) begin
      errors++;
      $display("FAIL add_wrap_cin: cins=%b want 1111", cins);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xor_zero();
    int lat;
    logic [3:0] cins;
    run_op(16'hA5A5, 16'hA5A5, 2'd3, 1'b1, lat, cins);
    checks++;
    if (lat != 4 || bus.out_result !== 16'h0000) begin
      errors++;
      $display("FAIL xor_result: lat=%0d result=%h want 4 0000",
               lat, bus.out_result);
    end
    checks++;
    if ({bus.out_cout, bus.out_n, bus.out_z, bus.out_v} !== 4'b0010) begin
      errors++;
      $display("FAIL xor_flags: cnzv=%b%b%b%b want 0010",
               bus.out_cout, bus.out_n, bus.out_z, bus.out_v);
    end
    checks++;
    if (cins !== 4'b0000) begin
      errors++;
      $display("FAIL xor_cin: cins=%b want 0000", cins);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_and_backpressure();
    int lat;
    logic [3:0] cins;
    bus.out_ready = 1'b0;
    run_op(16'hF0F0, 16'hFF00, 2'd1, 1'b0, lat, cins);
    checks++;
    if (lat != 4 || bus.out_result !== 16'hF000 || bus.out_n !== 1'b1
        || bus.out_z !== 1'b0) begin
      errors++;
      $display("FAIL and_result: lat=%0d result=%h n=%b z=%b want 4 f000 1 0",
               lat, bus.out_result, bus.out_n, bus.out_z);
    end
    bus.in_valid = 1'b1;
    bus.op_a     = 16'h1234;
    bus.op_b     = 16'h1111;
    bus.op_fn    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
          || bus.out_result !== 16'hF000 || alu_fn !== 2'd0) begin
        errors++;
        $display("FAIL and_stall%0d: valid=%b ready=%b result=%h want 1 0 f000",
                 i, bus.out_valid, bus.in_ready, bus.out_result);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
        || bus.out_result !== 16'hF000) begin
      errors++;
      $display("FAIL and_release: valid=%b ready=%b result=%h want 0 1 f000",
               bus.out_valid, bus.in_ready, bus.out_result);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL and_ignored_req: valid=%b ready=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [3:0] cins;
    bus.in_valid = 1'b1;
    bus.op_a     = 16'h1111;
    bus.op_b     = 16'h2222;
    bus.op_fn    = 2'd0;
    bus.op_cin   = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (alu_a !== 4'h1 || alu_b !== 4'h2) begin
      errors++;
      $display("FAIL abort_idx2: alu_a=%h alu_b=%h want 1 2", alu_a, alu_b);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
        || bus.out_result !== 16'h0000 || alu_a !== 4'h0) begin
      errors++;
      $display("FAIL abort_state: ready=%b valid=%b result=%h alu_a=%h want 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_result, alu_a);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result: valid=%b want 0", bus.out_valid);
    end
    run_op(16'h0F0F, 16'h00F0, 2'd2, 1'b1, lat, cins);
    checks++;
    if (lat != 4 || bus.out_result !== 16'h0FFF || bus.out_z !== 1'b0
        || bus.out_n !== 1'b0 || bus.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL or_after_abort: lat=%0d result=%h nzc=%b%b%b want 4 0fff 000",
               lat, bus.out_result, bus.out_n, bus.out_z, bus.out_cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [3:0] cins;
    run_op(16'h1234, 16'h4321, 2'd0, 1'b0, lat, cins);
    checks++;
    if (lat != 4 || bus.out_result !== 16'h5555) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d result=%h want 4 5555",
               lat, bus.out_result);
    end
    @(posedge clk); #1;
    run_op(16'h00FF, 16'h0F0F, 2'd3, 1'b0, lat, cins);
    checks++;
    if (lat != 4 || bus.out_result !== 16'h0FF0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d result=%h want 4 0ff0",
               lat, bus.out_result);
    end
    @(posedge clk); #1;
`ifdef ALU_SEQ_PERF_CNT_EN
    checks++;
    if (perf_ops !== 16'd2) begin
      errors++;
      $display("FAIL perf_count: got %0d want 2", perf_ops);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (perf_ops !== 16'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d want 0", perf_ops);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_fn     = '0;
    bus.op_cin    = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_overflow();
    test_add_wrap();
    test_xor_zero();
    test_and_backpressure();
    test_reset_mid_run();
    // fresh reset so the perf counter starts from zero
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
